// File: rtl/vga_timing_gen_if.sv
`timescale 1ns/1ps
// Purpose : bundle of raster timing outputs from vga_timing_gen to the pixel pipeline / DAC.
// Latency : n/a (wires only).
// Backpressure: none; the consumer must follow the timing as presented.
// Ports (master drives, slave reads):
//   pix_ce            one-clock pixel strobe
//   h_count, v_count  current raster position
//   h_sync, v_sync    sync levels (polarity set by the generator)
//   bright            current position is inside the active area
//   line_start        pixel strobe on column 0
//   frame_start       pixel strobe on (0,0)
//   pf_x, pf_y        position shown PREFETCH pixel ticks later
//   pf_valid          (pf_x, pf_y) is inside the active area
interface vga_timing_gen_if #(
   parameter int COUNTER_BITS = 10
) ();
   logic                    pix_ce;
   logic [COUNTER_BITS-1:0] h_count;
   logic [COUNTER_BITS-1:0] v_count;
   logic                    h_sync;
   logic                    v_sync;
   logic                    bright;
   logic                    line_start;
   logic                    frame_start;
   logic [COUNTER_BITS-1:0] pf_x;
   logic [COUNTER_BITS-1:0] pf_y;
   logic                    pf_valid;

   modport master (
      output pix_ce, h_count, v_count, h_sync, v_sync, bright,
             line_start, frame_start, pf_x, pf_y, pf_valid
   );

   modport slave (
      input  pix_ce, h_count, v_count, h_sync, v_sync, bright,
             line_start, frame_start, pf_x, pf_y, pf_valid
   );
endinterface

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// Purpose : parametrised VGA/LCD raster timing generator with pixel-clock divider and prefetch coordinates.
// Latency : syncs/bright/pf_* are registered in the same cycle as h_count/v_count (zero skew); first pix_ce CLK_DIV clocks after start.
// Backpressure: none; free-running while i_enable is high, i_enable low or i_clear low forces the start state.
// Ports:
//   i_clk_50MHz  system clock (single domain)
//   i_clear      asynchronous active-low reset
//   i_enable     synchronous run enable; low holds the reset state
//   o_vga        timing outputs (see vga_timing_gen_if)
module vga_timing_gen #(
   parameter int H_ACTIVE     = 640,
   parameter int H_FP         = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BP         = 48,
   parameter int V_ACTIVE     = 480,
   parameter int V_FP         = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BP         = 29,
   parameter int H_POL        = 0,
   parameter int V_POL        = 0,
   parameter int CLK_DIV      = 2,
   parameter int PREFETCH     = 2,
   parameter int COUNTER_BITS = 10
) (
   input  logic             i_clk_50MHz,
   input  logic             i_clear,
   input  logic             i_enable,
   vga_timing_gen_if.master o_vga
);
   localparam int CB       = COUNTER_BITS;
   localparam int CBW      = COUNTER_BITS + 1;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_BITS = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(CLK_DIV - 1);
   localparam logic [CB-1:0]       H_LAST   = CB'(H_TOTAL - 1);
   localparam logic [CB-1:0]       V_LAST   = CB'(V_TOTAL - 1);
   localparam logic [CBW-1:0]      H_TOT_W  = CBW'(H_TOTAL);
   localparam logic [CBW-1:0]      H_ACT_W  = CBW'(H_ACTIVE);
   localparam logic [CBW-1:0]      V_ACT_W  = CBW'(V_ACTIVE);
   localparam logic [CBW-1:0]      HS_LO    = CBW'(H_ACTIVE + H_FP);
   localparam logic [CBW-1:0]      HS_HI    = CBW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CBW-1:0]      VS_LO    = CBW'(V_ACTIVE + V_FP);
   localparam logic [CBW-1:0]      VS_HI    = CBW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CBW-1:0]      PF_STEP  = CBW'(PREFETCH);
   localparam logic                HS_ON    = (H_POL != 0);
   localparam logic                VS_ON    = (V_POL != 0);

   // Prefetch coordinates seen while parked at (H_TOTAL-1, V_TOTAL-1).
   localparam int             PF_R_SUM  = H_TOTAL - 1 + PREFETCH;
   localparam bit             PF_R_WRAP = (PF_R_SUM >= H_TOTAL);
   localparam int             PF_R_XI   = PF_R_WRAP ? (PF_R_SUM - H_TOTAL) : PF_R_SUM;
   localparam int             PF_R_YI   = PF_R_WRAP ? 0 : (V_TOTAL - 1);
   localparam logic [CB-1:0]  PF_R_X    = CB'(PF_R_XI);
   localparam logic [CB-1:0]  PF_R_Y    = CB'(PF_R_YI);
   localparam logic           PF_R_V    = (PF_R_XI < H_ACTIVE) && (PF_R_YI < V_ACTIVE);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DIV_BITS-1:0] r_div;
   logic [DIV_BITS-1:0] w_div_nxt;
   logic [CB-1:0]       r_h;
   logic [CB-1:0]       r_v;
   logic [CB-1:0]       w_h_nxt;
   logic [CB-1:0]       w_v_nxt;
   logic                r_hs;
   logic                r_vs;
   logic                r_bright;
   logic [CB-1:0]       r_pfx;
   logic [CB-1:0]       r_pfy;
   logic                r_pfv;

   logic                w_pix_ce;
   logic                w_line_start;
   logic [CBW-1:0]      w_h_ext;
   logic [CBW-1:0]      w_v_ext;
   logic                w_hs_nxt;
   logic                w_vs_nxt;
   logic                w_bright_nxt;
   logic [CBW-1:0]      w_pf_sum;
   logic [CBW-1:0]      w_pf_sub;
   logic                w_pf_wrap;
   logic [CB-1:0]       w_pfx_nxt;
   logic [CB-1:0]       w_pfy_nxt;
   logic                w_pfv_nxt;

   assign w_pix_ce = (r_state == ST_RUN) && (r_div == DIV_LAST);

   // Idle parks on the last raster position; the start edge steps onto (0,0)
   // exactly like a wrap, so the first displayed pixel opens a frame.
   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div;
      w_h_nxt     = r_h;
      w_v_nxt     = r_v;
      if (!i_enable) begin
         w_state_nxt = ST_IDLE;
         w_div_nxt   = '0;
         w_h_nxt     = H_LAST;
         w_v_nxt     = V_LAST;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_RUN;
               w_div_nxt   = '0;
               w_h_nxt     = '0;
               w_v_nxt     = '0;
            end
            ST_RUN: begin
               if (w_pix_ce) begin
                  w_div_nxt = '0;
                  if (r_h == H_LAST) begin
                     w_h_nxt = '0;
                     w_v_nxt = (r_v == V_LAST) ? '0 : r_v + 1'b1;
                  end else begin
                     w_h_nxt = r_h + 1'b1;
                  end
               end else begin
                  w_div_nxt = r_div + 1'b1;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Decode from the next position so the registered flags land in step with the counters.
   assign w_h_ext      = {1'b0, w_h_nxt};
   assign w_v_ext      = {1'b0, w_v_nxt};
   assign w_hs_nxt     = ((w_h_ext >= HS_LO) && (w_h_ext < HS_HI)) ? HS_ON : !HS_ON;
   assign w_vs_nxt     = ((w_v_ext >= VS_LO) && (w_v_ext < VS_HI)) ? VS_ON : !VS_ON;
   assign w_bright_nxt = (w_h_ext < H_ACT_W) && (w_v_ext < V_ACT_W);

   // PREFETCH never exceeds the blanking width, so at most one line carry.
   assign w_pf_sum  = w_h_ext + PF_STEP;
   assign w_pf_wrap = (w_pf_sum >= H_TOT_W);
   assign w_pf_sub  = w_pf_sum - H_TOT_W;
   assign w_pfx_nxt = w_pf_wrap ? w_pf_sub[CB-1:0] : w_pf_sum[CB-1:0];
   assign w_pfy_nxt = !w_pf_wrap ? w_v_nxt :
                      ((w_v_nxt == V_LAST) ? '0 : w_v_nxt + 1'b1);
   assign w_pfv_nxt = ({1'b0, w_pfx_nxt} < H_ACT_W) && ({1'b0, w_pfy_nxt} < V_ACT_W);

   always_ff @(posedge i_clk_50MHz or negedge i_clear) begin
      if (!i_clear) begin
         r_state  <= ST_IDLE;
         r_div    <= '0;
         r_h      <= H_LAST;
         r_v      <= V_LAST;
         r_hs     <= !HS_ON;
         r_vs     <= !VS_ON;
         r_bright <= 1'b0;
         r_pfx    <= PF_R_X;
         r_pfy    <= PF_R_Y;
         r_pfv    <= PF_R_V;
      end else begin
         r_state  <= w_state_nxt;
         r_div    <= w_div_nxt;
         r_h      <= w_h_nxt;
         r_v      <= w_v_nxt;
         r_hs     <= w_hs_nxt;
         r_vs     <= w_vs_nxt;
         r_bright <= w_bright_nxt;
         r_pfx    <= w_pfx_nxt;
         r_pfy    <= w_pfy_nxt;
         r_pfv    <= w_pfv_nxt;
      end
   end

   assign w_line_start = w_pix_ce && (r_h == '0);

   assign o_vga.pix_ce      = w_pix_ce;
   assign o_vga.h_count     = r_h;
   assign o_vga.v_count     = r_v;
   assign o_vga.h_sync      = r_hs;
   assign o_vga.v_sync      = r_vs;
   assign o_vga.bright      = r_bright;
   assign o_vga.line_start  = w_line_start;
   assign o_vga.frame_start = w_line_start && (r_v == '0);
   assign o_vga.pf_x        = r_pfx;
   assign o_vga.pf_y        = r_pfy;
   assign o_vga.pf_valid    = r_pfv;
endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Bench for vga_timing_gen: three instances (default timing, active-high syncs
// with CLK_DIV=1, and a tiny raster for frame-level behaviour) exercised one after
// another. Expected output vectors are hand-computed and queued with the clock
// count at which they must appear; a monitor pops and compares on the falling edge.
module tb_vga_timing_gen;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic clear_a, clear_b, clear_c;
   logic en_a, en_b, en_c;

   vga_timing_gen_if #(.COUNTER_BITS(10)) vif_a ();
   vga_timing_gen_if #(.COUNTER_BITS(10)) vif_b ();
   vga_timing_gen_if #(.COUNTER_BITS(10)) vif_c ();

   vga_timing_gen #(.CLK_DIV(2), .PREFETCH(2)) dut_a (
      .i_clk_50MHz(clk), .i_clear(clear_a), .i_enable(en_a), .o_vga(vif_a)
   );

   vga_timing_gen #(.H_POL(1), .V_POL(1), .CLK_DIV(1), .PREFETCH(2)) dut_b (
      .i_clk_50MHz(clk), .i_clear(clear_b), .i_enable(en_b), .o_vga(vif_b)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .CLK_DIV(3), .PREFETCH(2)
   ) dut_c (
      .i_clk_50MHz(clk), .i_clear(clear_c), .i_enable(en_c), .o_vga(vif_c)
   );

   // flags = {pix_ce, h_sync, v_sync, bright, line_start, frame_start}
   typedef struct {
      int unsigned t;
      int          d;
      string       name;
      int          h;
      int          v;
      logic [5:0]  fl;
      int          pfx;
      int          pfy;
      logic        pfv;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned t_clk = 0;
   int          n_total = 0;
   int          n_bad = 0;
   int          max_v_c = 0;

   always @(posedge clk) t_clk <= t_clk + 1;

   task automatic push(input int unsigned t, input int d, input string nm,
                       input int h, input int v, input logic [5:0] fl,
                       input int pfx, input int pfy, input logic pfv);
      exp_t e;
      e.t = t; e.d = d; e.name = nm; e.h = h; e.v = v; e.fl = fl;
      e.pfx = pfx; e.pfy = pfy; e.pfv = pfv;
      sb_q.push_back(e);
   endtask

   // Returns 2 ns after the edge that brings t_clk up to tt.
   task automatic wait_until(input int unsigned tt);
      while (t_clk < tt) begin
         @(posedge clk);
         #2;
      end
   endtask

   function automatic exp_t snap(input int d);
      exp_t s;
      s.t = t_clk; s.d = d; s.name = "";
      case (d)
         0: begin
            s.h = int'(vif_a.h_count); s.v = int'(vif_a.v_count);
            s.fl = {vif_a.pix_ce, vif_a.h_sync, vif_a.v_sync, vif_a.bright,
                    vif_a.line_start, vif_a.frame_start};
            s.pfx = int'(vif_a.pf_x); s.pfy = int'(vif_a.pf_y); s.pfv = vif_a.pf_valid;
         end
         1: begin
            s.h = int'(vif_b.h_count); s.v = int'(vif_b.v_count);
            s.fl = {vif_b.pix_ce, vif_b.h_sync, vif_b.v_sync, vif_b.bright,
                    vif_b.line_start, vif_b.frame_start};
            s.pfx = int'(vif_b.pf_x); s.pfy = int'(vif_b.pf_y); s.pfv = vif_b.pf_valid;
         end
         default: begin
            s.h = int'(vif_c.h_count); s.v = int'(vif_c.v_count);
            s.fl = {vif_c.pix_ce, vif_c.h_sync, vif_c.v_sync, vif_c.bright,
                    vif_c.line_start, vif_c.frame_start};
            s.pfx = int'(vif_c.pf_x); s.pfy = int'(vif_c.pf_y); s.pfv = vif_c.pf_valid;
         end
      endcase
      return s;
   endfunction

   // Monitor: compares every queued vector whose clock count has come due.
   initial begin
      exp_t e;
      exp_t o;
      forever begin
         @(negedge clk);
         if (int'(vif_c.v_count) > max_v_c) max_v_c = int'(vif_c.v_count);
         while (sb_q.size() > 0 && sb_q[0].t <= t_clk) begin
            e = sb_q.pop_front();
            o = snap(e.d);
            n_total++;
            if (e.t != t_clk || o.h != e.h || o.v != e.v || o.fl !== e.fl ||
                o.pfx != e.pfx || o.pfy != e.pfy || o.pfv !== e.pfv) begin
               n_bad++;
               $display("FAIL %s (dut %0d, clk %0d/%0d): got h=%0d v=%0d flags=%b pf=(%0d,%0d,%b) want h=%0d v=%0d flags=%b pf=(%0d,%0d,%b)",
                        e.name, e.d, t_clk, e.t, o.h, o.v, o.fl, o.pfx, o.pfy, o.pfv,
                        e.h, e.v, e.fl, e.pfx, e.pfy, e.pfv);
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned base;
      exp_t        e;
      clear_a = 1'b0; clear_b = 1'b0; clear_c = 1'b0;
      en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
      repeat (3) @(posedge clk);
      #2;

      // ---- default timing, CLK_DIV=2, PREFETCH=2 ----
      base = t_clk;
      push(base + 0,     0, "a_reset",        799, 520, 6'b011000,   1, 0, 1'b1);
      push(base + 1,     0, "a_start_00",       0,   0, 6'b011100,   2, 0, 1'b1);
      push(base + 2,     0, "a_first_ce",       0,   0, 6'b111111,   2, 0, 1'b1);
      push(base + 3,     0, "a_pixel1",         1,   0, 6'b011100,   3, 0, 1'b1);
      push(base + 1280,  0, "a_h639",         639,   0, 6'b111100, 641, 0, 1'b0);
      push(base + 1281,  0, "a_h640_dark",    640,   0, 6'b011000, 642, 0, 1'b0);
      push(base + 1311,  0, "a_h655_nosync",  655,   0, 6'b011000, 657, 0, 1'b0);
      push(base + 1313,  0, "a_h656_sync",    656,   0, 6'b001000, 658, 0, 1'b0);
      push(base + 1503,  0, "a_h751_sync",    751,   0, 6'b001000, 753, 0, 1'b0);
      push(base + 1505,  0, "a_h752_nosync",  752,   0, 6'b011000, 754, 0, 1'b0);
      push(base + 1599,  0, "a_h799_pfwrap",  799,   0, 6'b011000,   1, 1, 1'b1);
      push(base + 1602,  0, "a_line1_start",    0,   1, 6'b111110,   2, 1, 1'b1);
      push(base + 9277,  0, "a_pf_638_5",     638,   5, 6'b011100, 640, 5, 1'b0);
      push(base + 9597,  0, "a_pf_798_5",     798,   5, 6'b011000,   0, 6, 1'b1);
      push(base + 10201, 0, "a_at_300_6",     300,   6, 6'b011100, 302, 6, 1'b1);
      push(base + 10202, 0, "a_en_low",       799, 520, 6'b011000,   1, 0, 1'b1);
      push(base + 10205, 0, "a_en_low_held",  799, 520, 6'b011000,   1, 0, 1'b1);
      push(base + 10206, 0, "a_reen_00",        0,   0, 6'b011100,   2, 0, 1'b1);
      push(base + 10207, 0, "a_reen_frame",     0,   0, 6'b111111,   2, 0, 1'b1);
      push(base + 10405, 0, "a_h99",           99,   0, 6'b111100, 101, 0, 1'b1);
      push(base + 10406, 0, "a_clear_async",  799, 520, 6'b011000,   1, 0, 1'b1);
      push(base + 10408, 0, "a_clear_held",   799, 520, 6'b011000,   1, 0, 1'b1);
      push(base + 10409, 0, "a_reclear_00",     0,   0, 6'b011100,   2, 0, 1'b1);
      push(base + 10410, 0, "a_reclear_frame",  0,   0, 6'b111111,   2, 0, 1'b1);
      clear_a = 1'b1;
      wait_until(base + 10201);
      en_a = 1'b0;
      wait_until(base + 10205);
      en_a = 1'b1;
      wait_until(base + 10406);
      clear_a = 1'b0;
      wait_until(base + 10408);
      clear_a = 1'b1;
      wait_until(base + 10412);
      clear_a = 1'b0;

      // ---- active-high syncs, CLK_DIV=1 ----
      base = t_clk;
      push(base + 0,    1, "b_reset",        799, 520, 6'b000000,   1, 0, 1'b1);
      push(base + 1,    1, "b_first_ce",       0,   0, 6'b100111,   2, 0, 1'b1);
      push(base + 656,  1, "b_h655_nosync",  655,   0, 6'b100000, 657, 0, 1'b0);
      push(base + 657,  1, "b_h656_sync",    656,   0, 6'b110000, 658, 0, 1'b0);
      push(base + 752,  1, "b_h751_sync",    751,   0, 6'b110000, 753, 0, 1'b0);
      push(base + 753,  1, "b_h752_nosync",  752,   0, 6'b100000, 754, 0, 1'b0);
      push(base + 801,  1, "b_line1_start",    0,   1, 6'b100110,   2, 1, 1'b1);
      push(base + 1457, 1, "b_line1_sync",   656,   1, 6'b110000, 658, 1, 1'b0);
      clear_b = 1'b1;
      wait_until(base + 1460);
      clear_b = 1'b0;

      // ---- tiny raster 15x8, CLK_DIV=3: vertical sync and frame wrap ----
      base = t_clk;
      push(base + 0,   2, "c_reset",       14, 7, 6'b011000,  1, 0, 1'b1);
      push(base + 3,   2, "c_first_frame",  0, 0, 6'b111111,  2, 0, 1'b1);
      push(base + 28,  2, "c_h9",           9, 0, 6'b011000, 11, 0, 1'b0);
      push(base + 31,  2, "c_h10_sync",    10, 0, 6'b001000, 12, 0, 1'b0);
      push(base + 40,  2, "c_h13_pfwrap",  13, 0, 6'b011000,  0, 1, 1'b1);
      push(base + 136, 2, "c_v3_active",    0, 3, 6'b011100,  2, 3, 1'b1);
      push(base + 181, 2, "c_v4_porch",     0, 4, 6'b011000,  2, 4, 1'b0);
      push(base + 226, 2, "c_v5_vsync",     0, 5, 6'b010000,  2, 5, 1'b0);
      push(base + 313, 2, "c_v6_vsync",    14, 6, 6'b010000,  1, 7, 1'b0);
      push(base + 316, 2, "c_v7_novsync",   0, 7, 6'b011000,  2, 7, 1'b0);
      push(base + 358, 2, "c_last_pf00",   14, 7, 6'b011000,  1, 0, 1'b1);
      push(base + 360, 2, "c_last_ce",     14, 7, 6'b111000,  1, 0, 1'b1);
      push(base + 363, 2, "c_second_frame", 0, 0, 6'b111111,  2, 0, 1'b1);
      clear_c = 1'b1;
      wait_until(base + 366);
      clear_c = 1'b0;

      n_total++;
      if (max_v_c != 7) begin
         n_bad++;
         $display("FAIL c_vmax: got max v_count=%0d want 7", max_v_c);
      end

      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_total++;
         n_bad++;
         $display("FAIL %s: never compared (due clk %0d, now %0d)", e.name, e.t, t_clk);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
